// File: rtl/updown_cnt_arb.sv
// updown_cnt_arb: round-robin arbiter sharing one WIDTH-bit up/down counter
// between requesters A and B, granting at most one step per clock.
// Ports: clk, rst (sync, active-high), en, req_a/dir_a, req_b/dir_b in;
// gnt_a/gnt_b (registered one-cycle acks) and out (count) out.
// Build option: define CNT_SAT_EN to saturate at 0 / 2^WIDTH-1 instead of wrapping.
module updown_cnt_arb #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             req_a,
  input  logic             dir_a,
  input  logic             req_b,
  input  logic             dir_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic [WIDTH-1:0] out
);

  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } last_t;

  localparam logic [WIDTH-1:0] MAX = '1;

  last_t            last;
  logic             elig_a;
  logic             elig_b;
  logic             pick_a;
  logic             pick_b;
  logic             dir;
  logic [WIDTH-1:0] nxt;

  // A requester acked this cycle is masked so a held req
  // counts as a new request only from the following cycle.
  always_comb begin
    elig_a = req_a & ~gnt_a;
    elig_b = req_b & ~gnt_b;
    pick_a = elig_a & (~elig_b | (last == LAST_B));
    pick_b = elig_b & ~pick_a;
    dir    = pick_a ? dir_a : dir_b;
    nxt    = out;
`ifdef CNT_SAT_EN
    if (dir && out != MAX)
      nxt = out + 1'b1;
    else if (!dir && out != '0)
      nxt = out - 1'b1;
`else
    nxt = dir ? out + 1'b1 : out - 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out   <= '0;
      gnt_a <= 1'b0;
      gnt_b <= 1'b0;
      last  <= LAST_B;
    end else if (!en) begin
      gnt_a <= 1'b0;
      gnt_b <= 1'b0;
    end else begin
      gnt_a <= pick_a;
      gnt_b <= pick_b;
      if (pick_a || pick_b) begin
        last <= pick_a ? LAST_A : LAST_B;
        out  <= nxt;
      end
    end
  end

endmodule

// File: tb/tb_updown_cnt_arb.sv
// tb_updown_cnt_arb: directed self-checking bench for updown_cnt_arb.
// Each check compares {gnt_a, gnt_b, out} against a hand-computed value.
module tb_updown_cnt_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       req_a = 1'b0;
  logic       dir_a = 1'b0;
  logic       req_b = 1'b0;
  logic       dir_b = 1'b0;
  logic       gnt_a;
  logic       gnt_b;
  logic [2:0] out;

  int total = 0;
  int bad = 0;

  updown_cnt_arb #(.WIDTH(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .req_a (req_a),
    .dir_a (dir_a),
    .req_b (req_b),
    .dir_b (dir_b),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b),
    .out   (out)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [4:0] exp;
    rst = 1'b1; en = 1'b1;
    req_a = 1'b1; dir_a = 1'b1;
    req_b = 1'b1; dir_b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick;
      exp = 5'b00_000;
      total++;
      if ({gnt_a, gnt_b, out} !== exp) begin
        bad++;
        $display("FAIL reset[%0d] got=%b want=%b", i, {gnt_a, gnt_b, out}, exp);
      end
    end
    rst = 1'b0;
    tick;
    exp = 5'b10_001;
    total++;
    if ({gnt_a, gnt_b, out} !== exp) begin
      bad++;
      $display("FAIL reset_first_a got=%b want=%b", {gnt_a, gnt_b, out}, exp);
    end
    req_a = 1'b0; req_b = 1'b0;
    tick;
    exp = 5'b00_001;
    total++;
    if ({gnt_a, gnt_b, out} !== exp) begin
      bad++;
      $display("FAIL reset_idle got=%b want=%b", {gnt_a, gnt_b, out}, exp);
    end
  endtask

  task automatic test_single;
    logic [4:0] exp;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_a = 1'b1; dir_a = 1'b1;
      tick;
      exp = {2'b10, 3'(i + 1)};
      total++;
      if ({gnt_a, gnt_b, out} !== exp) begin
        bad++;
        $display("FAIL single_gnt[%0d] got=%b want=%b", i, {gnt_a, gnt_b, out}, exp);
      end
      req_a = 1'b0;
      tick;
      exp = {2'b00, 3'(i + 1)};
      total++;
      if ({gnt_a, gnt_b, out} !== exp) begin
        bad++;
        $display("FAIL single_drop[%0d] got=%b want=%b", i, {gnt_a, gnt_b, out}, exp);
      end
    end
  endtask

  task automatic test_contention;
    logic [4:0] exp;
    logic [4:0] tab [4];
    tab = '{5'b10_100, 5'b01_011, 5'b10_100, 5'b01_011};
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_b = 1'b1; dir_b = 1'b1;
      tick;
      exp = {2'b01, 3'(i + 1)};
      total++;
      if ({gnt_a, gnt_b, out} !== exp) begin
        bad++;
        $display("FAIL cont_setup[%0d] got=%b want=%b", i, {gnt_a, gnt_b, out}, exp);
      end
      req_b = 1'b0;
      tick;
    end
    req_a = 1'b1; dir_a = 1'b1;
    req_b = 1'b1; dir_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      exp = tab[i];
      total++;
      if ({gnt_a, gnt_b, out} !== exp) begin
        bad++;
        $display("FAIL contention[%0d] got=%b want=%b", i, {gnt_a, gnt_b, out}, exp);
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    tick;
    exp = 5'b00_011;
    total++;
    if ({gnt_a, gnt_b, out} !== exp) begin
      bad++;
      $display("FAIL cont_idle got=%b want=%b", {gnt_a, gnt_b, out}, exp);
    end
  endtask

  task automatic test_wrap;
    logic [4:0] exp;
    for (int i = 0; i < 4; i++) begin
      req_a = 1'b1; dir_a = 1'b1;
      tick;
      exp = {2'b10, 3'(i + 4)};
      total++;
      if ({gnt_a, gnt_b, out} !== exp) begin
        bad++;
        $display("FAIL wrap_climb[%0d] got=%b want=%b", i, {gnt_a, gnt_b, out}, exp);
      end
      req_a = 1'b0;
      tick;
    end
    req_a = 1'b1; dir_a = 1'b1;
    tick;
`ifdef CNT_SAT_EN
    exp = 5'b10_111;
`else
    exp = 5'b10_000;
`endif
    total++;
    if ({gnt_a, gnt_b, out} !== exp) begin
      bad++;
      $display("FAIL top_edge got=%b want=%b", {gnt_a, gnt_b, out}, exp);
    end
    req_a = 1'b0;
    tick;
`ifdef CNT_SAT_EN
    rst = 1'b1;
    tick;
    rst = 1'b0;
    exp = 5'b01_000;
`else
    exp = 5'b01_111;
`endif
    req_b = 1'b1; dir_b = 1'b0;
    tick;
    total++;
    if ({gnt_a, gnt_b, out} !== exp) begin
      bad++;
      $display("FAIL bottom_edge got=%b want=%b", {gnt_a, gnt_b, out}, exp);
    end
    req_b = 1'b0;
    tick;
  endtask

  task automatic test_enable;
    logic [4:0] exp;
    rst = 1'b1;
    tick;
    rst = 1'b0; en = 1'b0;
    req_a = 1'b1; dir_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      exp = 5'b00_000;
      total++;
      if ({gnt_a, gnt_b, out} !== exp) begin
        bad++;
        $display("FAIL en_low[%0d] got=%b want=%b", i, {gnt_a, gnt_b, out}, exp);
      end
    end
    en = 1'b1;
    tick;
    exp = 5'b10_001;
    total++;
    if ({gnt_a, gnt_b, out} !== exp) begin
      bad++;
      $display("FAIL en_resume got=%b want=%b", {gnt_a, gnt_b, out}, exp);
    end
    req_a = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) begin
      req_a = 1'b1;
      tick;
      exp = {2'b10, 3'(i + 2)};
      total++;
      if ({gnt_a, gnt_b, out} !== exp) begin
        bad++;
        $display("FAIL en_climb[%0d] got=%b want=%b", i, {gnt_a, gnt_b, out}, exp);
      end
      req_a = 1'b0;
      tick;
    end
    req_b = 1'b1; dir_b = 1'b1; rst = 1'b1;
    tick;
    exp = 5'b00_000;
    total++;
    if ({gnt_a, gnt_b, out} !== exp) begin
      bad++;
      $display("FAIL rst_pending got=%b want=%b", {gnt_a, gnt_b, out}, exp);
    end
    rst = 1'b0;
    tick;
    exp = 5'b01_001;
    total++;
    if ({gnt_a, gnt_b, out} !== exp) begin
      bad++;
      $display("FAIL rst_rearb got=%b want=%b", {gnt_a, gnt_b, out}, exp);
    end
    req_b = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    logic [4:0] exp;
    logic [4:0] tab [4];
    tab = '{5'b10_010, 5'b00_010, 5'b10_011, 5'b00_011};
    req_a = 1'b1; dir_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      exp = tab[i];
      total++;
      if ({gnt_a, gnt_b, out} !== exp) begin
        bad++;
        $display("FAIL b2b[%0d] got=%b want=%b", i, {gnt_a, gnt_b, out}, exp);
      end
    end
    req_a = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_single;
    test_contention;
    test_wrap;
    test_enable;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
